// File: rtl/prbs_nrz_ramp_shaper.sv
// rtl/prbs_nrz_ramp_shaper.sv - PRBS bit stream to DAC samples with linear rise/fall ramps
// Optional macro PRBS_RAMP_OUTPUT_REG_EN adds one register stage on every output.
module prbs_nrz_ramp_shaper #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              dac_clk,
  input  logic              reset,
  input  logic              prbs_bit_out,
  input  logic              lfsr_clk_enable,
  input  logic [DATA_W-1:0] level_low,
  input  logic [DATA_W-1:0] level_high,
  input  logic [DATA_W-1:0] rise_step,
  input  logic [DATA_W-1:0] fall_step,
  output logic [DATA_W-1:0] shaped_prbs_data,
  output logic [1:0]        edge_state_dbg,
  output logic [CNT_W-1:0]  edge_counter_dbg,
  output logic              edge_busy
);

  typedef enum logic [1:0] {
    STEADY_LOW   = 2'b00,
    RISING_EDGE  = 2'b01,
    STEADY_HIGH  = 2'b10,
    FALLING_EDGE = 2'b11
  } edge_state_t;

  edge_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              target_bit;
  logic              edge_start;
  logic              ramp_bit;
  logic              ramp_up;
  logic              ramp_land;
  logic              in_edge;
  logic [DATA_W-1:0] ramp_target;
  logic [DATA_W-1:0] ramp_step;
  logic [DATA_W:0]   ramp_diff;

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state_q <= STEADY_LOW;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = '0;
    target_bit  = (state_q == RISING_EDGE) || (state_q == STEADY_HIGH);
    in_edge     = (state_q == RISING_EDGE) || (state_q == FALLING_EDGE);
    edge_start  = lfsr_clk_enable && (prbs_bit_out != target_bit);
    // A strobe (including a reversal) retargets the ramp from the current sample.
    ramp_bit    = edge_start ? prbs_bit_out : target_bit;
    ramp_target = ramp_bit ? level_high : level_low;
    ramp_step   = ramp_bit ? rise_step : fall_step;
    ramp_up     = ramp_target > data_q;
    ramp_diff   = ramp_up ? ({1'b0, ramp_target} - {1'b0, data_q})
                          : ({1'b0, data_q} - {1'b0, ramp_target});
    ramp_land   = (ramp_step == '0) || (ramp_diff <= {1'b0, ramp_step});

    if (edge_start || in_edge) begin
      if (ramp_land) begin
        data_d  = ramp_target;
        state_d = ramp_bit ? STEADY_HIGH : STEADY_LOW;
        cnt_d   = '0;
      end else begin
        data_d  = ramp_up ? (data_q + ramp_step) : (data_q - ramp_step);
        state_d = ramp_bit ? RISING_EDGE : FALLING_EDGE;
        if (edge_start)
          cnt_d = CNT_W'(1);
        else
          cnt_d = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));
      end
    end else begin
      data_d = target_bit ? level_high : level_low;
    end
  end

`ifdef PRBS_RAMP_OUTPUT_REG_EN
  always_ff @(posedge dac_clk) begin
    if (reset) begin
      shaped_prbs_data <= '0;
      edge_state_dbg   <= '0;
      edge_counter_dbg <= '0;
      edge_busy        <= 1'b0;
    end else begin
      shaped_prbs_data <= data_q;
      edge_state_dbg   <= state_q;
      edge_counter_dbg <= cnt_q;
      edge_busy        <= state_q[0];
    end
  end
`else
  assign shaped_prbs_data = data_q;
  assign edge_state_dbg   = state_q;
  assign edge_counter_dbg = cnt_q;
  assign edge_busy        = state_q[0];
`endif

endmodule

// File: tb/tb_prbs_nrz_ramp_shaper.sv
// tb/tb_prbs_nrz_ramp_shaper.sv - directed self-checking bench for prbs_nrz_ramp_shaper
module tb_prbs_nrz_ramp_shaper;

  logic        dac_clk = 1'b0;
  logic        reset;
  logic        prbs_bit_out;
  logic        lfsr_clk_enable;
  logic [15:0] level_low;
  logic [15:0] level_high;
  logic [15:0] rise_step;
  logic [15:0] fall_step;
  logic [15:0] shaped_prbs_data;
  logic [1:0]  edge_state_dbg;
  logic [7:0]  edge_counter_dbg;
  logic        edge_busy;

  int errors = 0;
  int checks = 0;

  prbs_nrz_ramp_shaper #(.DATA_W(16), .CNT_W(8)) dut (
    .dac_clk          (dac_clk),
    .reset            (reset),
    .prbs_bit_out     (prbs_bit_out),
    .lfsr_clk_enable  (lfsr_clk_enable),
    .level_low        (level_low),
    .level_high       (level_high),
    .rise_step        (rise_step),
    .fall_step        (fall_step),
    .shaped_prbs_data (shaped_prbs_data),
    .edge_state_dbg   (edge_state_dbg),
    .edge_counter_dbg (edge_counter_dbg),
    .edge_busy        (edge_busy)
  );

  always #5 dac_clk = ~dac_clk;

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] data, input logic [1:0] st,
                           input logic [7:0] cnt, input logic busy);
    check({tag, ".data"}, 32'(shaped_prbs_data), 32'(data));
    check({tag, ".state"}, 32'(edge_state_dbg), 32'(st));
    check({tag, ".cnt"}, 32'(edge_counter_dbg), 32'(cnt));
    check({tag, ".busy"}, 32'(edge_busy), 32'(busy));
  endtask

  initial begin
    reset           = 1'b1;
    prbs_bit_out    = 1'b0;
    lfsr_clk_enable = 1'b0;
    level_low       = 16'h1000;
    level_high      = 16'h9000;
    rise_step       = 16'h0800;
    fall_step       = 16'h0700;
    tick();
    check_all("reset", 16'h0000, 2'b00, 8'd0, 1'b0);

    reset = 1'b0;
    tick();
    check_all("load_low", 16'h1000, 2'b00, 8'd0, 1'b0);

    // Clean rise, exact division: 15 ramp steps then landing on the 16th clock
    prbs_bit_out    = 1'b1;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    check_all("rise_1", 16'h1800, 2'b01, 8'd1, 1'b1);
    for (int i = 2; i <= 15; i++) begin
      tick();
      check_all("rise_n", 16'(16'h1000 + i * 16'h0800), 2'b01, 8'(i), 1'b1);
    end
    tick();
    check_all("rise_land", 16'h9000, 2'b10, 8'd0, 1'b0);

    // Non-divisible fall: 18 steps of 0x0700 reach 0x1200, the 19th clamps
    prbs_bit_out    = 1'b0;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    check_all("fall_1", 16'h8900, 2'b11, 8'd1, 1'b1);
    for (int i = 2; i <= 18; i++) begin
      tick();
      check_all("fall_n", 16'(16'h9000 - i * 16'h0700), 2'b11, 8'(i), 1'b1);
    end
    tick();
    check_all("fall_land", 16'h1000, 2'b00, 8'd0, 1'b0);

    // Hard edge
    rise_step       = 16'h0000;
    prbs_bit_out    = 1'b1;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    check_all("hard_rise", 16'h9000, 2'b10, 8'd0, 1'b0);

    // Steady retune and enable gating
    level_high = 16'hA000;
    tick();
    check_all("retune", 16'hA000, 2'b10, 8'd0, 1'b0);
    prbs_bit_out = 1'b0;
    tick();
    prbs_bit_out = 1'b1;
    tick();
    prbs_bit_out = 1'b0;
    tick();
    check_all("gated", 16'hA000, 2'b10, 8'd0, 1'b0);
    prbs_bit_out    = 1'b1;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    check_all("same_bit", 16'hA000, 2'b10, 8'd0, 1'b0);

    // Back to low with a hard fall, then rise and reverse at 0x4000
    level_high      = 16'h9000;
    rise_step       = 16'h0800;
    fall_step       = 16'h0000;
    prbs_bit_out    = 1'b0;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    check_all("hard_fall", 16'h1000, 2'b00, 8'd0, 1'b0);
    fall_step       = 16'h1000;
    prbs_bit_out    = 1'b1;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    for (int i = 2; i <= 6; i++) tick();
    check_all("pre_rev", 16'h4000, 2'b01, 8'd6, 1'b1);
    prbs_bit_out    = 1'b0;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    check_all("rev_1", 16'h3000, 2'b11, 8'd1, 1'b1);
    tick();
    check_all("rev_2", 16'h2000, 2'b11, 8'd2, 1'b1);
    tick();
    check_all("rev_land", 16'h1000, 2'b00, 8'd0, 1'b0);

    // Reset mid-edge at 0x5000
    prbs_bit_out    = 1'b1;
    lfsr_clk_enable = 1'b1;
    tick();
    lfsr_clk_enable = 1'b0;
    for (int i = 2; i <= 8; i++) tick();
    check_all("pre_rst", 16'h5000, 2'b01, 8'd8, 1'b1);
    reset = 1'b1;
    tick();
    check_all("rst_mid", 16'h0000, 2'b00, 8'd0, 1'b0);
    reset = 1'b0;
    tick();
    check_all("post_rst", 16'h1000, 2'b00, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
